seg7_reader: RTL

SEG7_READER -- requirements
Module: seg7_reader

---
 rtl/seg7_reader.sv | 109 ++++++++++
 1 files changed

// File: rtl/seg7_reader.sv
// Seven-segment frame reader: scans one digit per cycle, decoding SEG_ONE/SEG_ZERO
// patterns to bits and flagging any other pattern as illegal.
module seg7_reader #(
  parameter int unsigned DIGITS   = 6,
  parameter logic [6:0]  SEG_ONE  = 7'b0110000,
  parameter logic [6:0]  SEG_ZERO = 7'b1111110
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7*DIGITS-1:0]   display,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIGITS-1:0]     bits,
  output logic                  err,
  output logic [DIGITS-1:0]     err_mask,
  output logic [7:0]            err_count
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FW = 7 * DIGITS;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state_q, state_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] bits_d, mask_d;
  logic [7:0]        cnt_d;
  logic [6:0]        digit;
  logic [1:0]        rst_sync;
  logic              rst_int_n;

  // Reset asserts immediately, releases two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      idx_q     <= '0;
      bits      <= '0;
      err_mask  <= '0;
      err       <= 1'b0;
      err_count <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      idx_q     <= idx_d;
      bits      <= bits_d;
      err_mask  <= mask_d;
      err       <= |mask_d;
      err_count <= cnt_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    bits_d  = bits;
    mask_d  = err_mask;
    cnt_d   = err_count;
    digit   = frame_q[7*int'(idx_q) +: 7];
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          frame_d = display;
          idx_d   = '0;
          bits_d  = '0;
          mask_d  = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (digit == SEG_ONE) begin
          bits_d[idx_q] = 1'b1;
        end else if (digit == SEG_ZERO) begin
          bits_d[idx_q] = 1'b0;
        end else begin
          bits_d[idx_q] = 1'b0;
          mask_d[idx_q] = 1'b1;
        end
        if (idx_q == IW'(DIGITS - 1)) begin
          state_d = DONE;
          // Count is taken from the mask including the digit decoded this cycle.
          if ((|mask_d) && (err_count != 8'hFF)) cnt_d = err_count + 8'd1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
